// File: rtl/flash_model.sv
// flash_model: synthesizable NOR flash responder with command decode, program/erase busy timing and status register.
// Optional identifier read mode is built when FLASH_MODEL_ID_EN is defined.
module flash_model #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_W     = 6,
  parameter int PROG_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] flash_addr,
  inout  wire  [15:0] flash_data,
  input  logic [7:0]  flash_ctl,
  output logic        ready
);

  localparam int CNT_W       = 16;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int BLOCK_WORDS = 1 << BLOCK_W;

  typedef enum logic [2:0] {
    READ_ARRAY,
    READ_STATUS,
`ifdef FLASH_MODEL_ID_EN
    READ_ID,
`endif
    PROG_SETUP,
    PROG_BUSY,
    ERASE_SETUP,
    ERASE_BUSY
  } mode_t;

  mode_t             r_mode;
  mode_t             w_nextMode;
  logic              r_weQ;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_srDone;
  logic              r_srErase;
  logic              r_srProg;
  logic              r_srVpp;
  logic [15:0]       r_mem [DEPTH];
  logic [15:0]       r_rdData;
  logic [7:0]        w_sr;
  logic [15:0]       w_rdOut;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [15:0]       w_memWdata;

  wire               w_ceN      = flash_ctl[6];
  wire               w_oeN      = flash_ctl[3];
  wire               w_rpN      = flash_ctl[2];
  wire               w_vpen     = flash_ctl[1];
  wire               w_weN      = flash_ctl[0];
  wire [ADDR_W-1:0]  w_wordAddr = flash_addr[ADDR_W:1];
  wire [7:0]         w_cmd      = flash_data[7:0];
  wire               w_cmdEdge  = !r_weQ && w_weN && !w_ceN;
  wire               w_busy     = (r_mode == PROG_BUSY) || (r_mode == ERASE_BUSY);
  wire               w_progDone = (r_mode == PROG_BUSY) && (r_cnt == CNT_W'(PROG_CYCLES - 1));
  wire               w_eraseDone = (r_mode == ERASE_BUSY) && (r_cnt == CNT_W'(BLOCK_WORDS - 1));
  wire               w_busEn    = !w_ceN && !w_oeN && w_rpN && !rst;
  wire               w_unused   = ^{flash_addr[22:ADDR_W+1], flash_addr[0], flash_ctl[7], flash_ctl[5:4]};

  assign w_sr = {r_srDone, 1'b0, r_srErase, r_srProg, r_srVpp, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_weQ <= 1'b1;
    else     r_weQ <= w_weN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_mode <= READ_ARRAY;
    else if (!w_rpN) r_mode <= READ_ARRAY;
    else             r_mode <= w_nextMode;
  end

  // Busy completion is evaluated before any command, so a coincident edge is dropped.
  always_comb begin
    w_nextMode = r_mode;
    case (r_mode)
      PROG_SETUP:  if (w_cmdEdge) w_nextMode = w_vpen ? PROG_BUSY : READ_STATUS;
      PROG_BUSY:   if (w_progDone) w_nextMode = READ_STATUS;
      ERASE_SETUP: if (w_cmdEdge) w_nextMode = (w_cmd == 8'hD0 && w_vpen) ? ERASE_BUSY : READ_STATUS;
      ERASE_BUSY:  if (w_eraseDone) w_nextMode = READ_STATUS;
      default: begin
        if (w_cmdEdge) begin
          case (w_cmd)
            8'hFF:        w_nextMode = READ_ARRAY;
            8'h70:        w_nextMode = READ_STATUS;
            8'h40, 8'h10: w_nextMode = PROG_SETUP;
            8'h20:        w_nextMode = ERASE_SETUP;
`ifdef FLASH_MODEL_ID_EN
            8'h90:        w_nextMode = READ_ID;
`endif
            default:      w_nextMode = r_mode;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    ready      = 1'b1;
    w_memWe    = 1'b0;
    w_memAddr  = r_addr;
    w_memWdata = r_mem[r_addr] & r_data;
    case (r_mode)
      PROG_BUSY: begin
        ready   = 1'b0;
        w_memWe = w_progDone;
      end
      ERASE_BUSY: begin
        ready      = 1'b0;
        w_memWe    = 1'b1;
        w_memAddr  = {r_addr[ADDR_W-1:BLOCK_W], r_cnt[BLOCK_W-1:0]};
        w_memWdata = 16'hFFFF;
      end
      default: ready = 1'b1;
    endcase
    if (!w_rpN) w_memWe = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_srDone  <= 1'b1;
      r_srErase <= 1'b0;
      r_srProg  <= 1'b0;
      r_srVpp   <= 1'b0;
    end else if (!w_rpN) begin
      r_cnt     <= '0;
      r_srDone  <= 1'b1;
      r_srErase <= 1'b0;
      r_srProg  <= 1'b0;
      r_srVpp   <= 1'b0;
    end else begin
      if (w_cmdEdge && !w_busy) begin
        r_addr <= w_wordAddr;
        r_data <= flash_data;
      end
      case (r_mode)
        PROG_SETUP: begin
          if (w_cmdEdge) begin
            if (w_vpen) begin
              r_srDone <= 1'b0;
              r_cnt    <= '0;
            end else begin
              r_srProg <= 1'b1;
              r_srVpp  <= 1'b1;
            end
          end
        end
        PROG_BUSY: begin
          if (w_progDone) r_srDone <= 1'b1;
          else            r_cnt    <= r_cnt + 1'b1;
        end
        ERASE_SETUP: begin
          if (w_cmdEdge) begin
            if (w_cmd != 8'hD0) begin
              r_srErase <= 1'b1;
              r_srProg  <= 1'b1;
            end else if (!w_vpen) begin
              r_srErase <= 1'b1;
              r_srVpp   <= 1'b1;
            end else begin
              r_srDone <= 1'b0;
              r_cnt    <= '0;
            end
          end
        end
        ERASE_BUSY: begin
          if (w_eraseDone) r_srDone <= 1'b1;
          else             r_cnt    <= r_cnt + 1'b1;
        end
        default: begin
          if (w_cmdEdge && w_cmd == 8'h50) begin
            r_srErase <= 1'b0;
            r_srProg  <= 1'b0;
            r_srVpp   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array contents survive reset, so the RAM has no reset term.
  always_ff @(posedge clk) begin
    if (w_memWe) r_mem[w_memAddr] <= w_memWdata;
    r_rdData <= r_mem[w_wordAddr];
  end

`ifdef FLASH_MODEL_ID_EN
  logic [15:0] r_idData;

  always_ff @(posedge clk) begin
    case (w_wordAddr)
      ADDR_W'(0): r_idData <= 16'h0089;
      ADDR_W'(1): r_idData <= 16'h0018;
      default:    r_idData <= 16'h0000;
    endcase
  end
`endif

  always_comb begin
    w_rdOut = {8'h00, w_sr};
    if (r_mode == READ_ARRAY) w_rdOut = r_rdData;
`ifdef FLASH_MODEL_ID_EN
    else if (r_mode == READ_ID) w_rdOut = r_idData;
`endif
  end

  assign flash_data = w_busEn ? w_rdOut : 16'bz;

endmodule

// File: tb/tb_flash_model.sv
// tb_flash_model: randomized scoreboard bench for flash_model against an array/status reference model.
// Expectations follow FLASH_MODEL_ID_EN when it is defined for the build.
module tb_flash_model;

  localparam int PROG_CYCLES = 8;
  localparam int BLOCK_WORDS = 64;
  localparam int WORDS       = 1024;

  typedef struct {
    string       name;
    bit          isReady;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] flashAddr;
  logic [15:0] tbData;
  logic        tbDrive;
  logic        byteSig, ceN, oeN, rpN, vpen, weN;
  logic        ready;
  wire  [15:0] flash_data;
  wire  [7:0]  flashCtl = {byteSig, ceN, 1'b1, 1'b0, oeN, rpN, vpen, weN};

  assign flash_data = tbDrive ? tbData : 16'bz;

  flash_model #(.ADDR_W(10), .BLOCK_W(6), .PROG_CYCLES(PROG_CYCLES)) dut (
    .clk(clk), .rst(rst), .flash_addr(flashAddr), .flash_data(flash_data),
    .flash_ctl(flashCtl), .ready(ready)
  );

  always #5 clk = ~clk;

  exp_t        expQ[$];
  int          busyQ[$];
  logic [15:0] modelMem [WORDS];
  logic [7:0]  modelSr;
  int          checks = 0;
  int          errors = 0;
  int          busyRun = 0;
  int          tmoEvents = 0;
  int          tmoSeen = 0;
  bit          strobe, monEn, endReq;
  bit          endDone = 0;

  // Monitor: pops the scoreboard on each strobe and measures every low period of ready.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    int          expBusy;
    if (monEn) begin
      if (strobe) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_sample got none expected an entry");
        end else begin
          e   = expQ.pop_front();
          act = e.isReady ? {15'b0, ready} : flash_data;
          if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", e.name, act, e.exp);
          end
        end
      end
      if (!ready) busyRun++;
      else if (busyRun != 0) begin
        checks++;
        expBusy = (busyQ.size() != 0) ? busyQ.pop_front() : 0;
        if (busyRun != expBusy) begin
          errors++;
          $display("[TB] FAIL busy_length got %0d expected %0d", busyRun, expBusy);
        end
        busyRun = 0;
      end
      if (tmoEvents != tmoSeen) begin
        checks++;
        errors++;
        $display("[TB] FAIL ready_timeout got busy expected ready within bound");
        tmoSeen = tmoEvents;
      end
      if (endReq && !endDone) begin
        checks++;
        if (expQ.size() != 0 || busyQ.size() != 0) begin
          errors++;
          $display("[TB] FAIL leftover_expectations got %0d/%0d expected 0/0", expQ.size(), busyQ.size());
        end
        endDone = 1;
      end
    end
  end

  function automatic logic [22:0] wa(input int w);
    return {12'b0, w[9:0], 1'b0};
  endfunction

  task automatic applyStimulus(input logic [22:0] addr, input logic [15:0] data);
    flashAddr = addr;
    tbData    = data;
    tbDrive   = 1'b1;
    weN       = 1'b0;
    @(posedge clk); #1;
    weN = 1'b1;
    @(posedge clk); #1;
    tbDrive = 1'b0;
  endtask

  task automatic checkOutput(input logic [22:0] addr, input logic [15:0] exp, input string name);
    flashAddr = addr;
    oeN       = 1'b0;
    @(posedge clk); #1;
    expQ.push_back('{name: name, isReady: 1'b0, exp: exp});
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    oeN    = 1'b1;
  endtask

  task automatic checkReady(input logic exp, input string name);
    expQ.push_back('{name: name, isReady: 1'b1, exp: {15'b0, exp}});
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic waitReady(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) tmoEvents++;
    @(posedge clk); #1;
  endtask

  task automatic checkStatus(input string name);
    checkOutput(wa(0), {8'h00, modelSr}, name);
  endtask

  task automatic readArray(input int w, input string name);
    logic [11:0] hi;
    logic        lo;
    hi = 12'($urandom);
    lo = 1'($urandom);
    applyStimulus(wa(0), 16'h00FF);
    checkOutput({hi, w[9:0], lo}, modelMem[w], name);
  endtask

  task automatic programWord(input int w, input logic [15:0] data);
    applyStimulus(wa(w), 16'h0040);
    if (vpen) busyQ.push_back(PROG_CYCLES);
    applyStimulus(wa(w), data);
    if (vpen) begin
      waitReady(PROG_CYCLES + 20);
      modelMem[w] = modelMem[w] & data;
      modelSr[7]  = 1'b1;
    end else begin
      modelSr = modelSr | 8'h18;
    end
  endtask

  task automatic eraseBlock(input int w);
    int base;
    base = w & ~(BLOCK_WORDS - 1);
    applyStimulus(wa(w), 16'h0020);
    busyQ.push_back(BLOCK_WORDS);
    applyStimulus(wa(w), 16'h00D0);
    waitReady(BLOCK_WORDS + 20);
    for (int i = 0; i < BLOCK_WORDS; i++) modelMem[base + i] = 16'hFFFF;
    modelSr[7] = 1'b1;
  endtask

  initial begin
    int abortAt;
    int base;
    int op;
    int w;
    rst = 1'b1; weN = 1'b1; ceN = 1'b0; oeN = 1'b1; rpN = 1'b1; vpen = 1'b1; byteSig = 1'b0;
    tbDrive = 1'b0; tbData = '0; flashAddr = '0; strobe = 1'b0; monEn = 1'b0; endReq = 1'b0;
    modelSr = 8'h80;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    monEn = 1'b1;

    checkReady(1'b1, "reset_ready");
    applyStimulus(wa(0), 16'h0070);
    checkStatus("reset_status");

    for (int b = 0; b < WORDS / BLOCK_WORDS; b++) eraseBlock(b * BLOCK_WORDS);

    // Program word 5, sampling status while the device is busy.
    applyStimulus(wa(5), 16'h0040);
    busyQ.push_back(PROG_CYCLES);
    applyStimulus(wa(5), 16'h1234);
    checkOutput(wa(5), 16'h0000, "status_during_busy");
    waitReady(PROG_CYCLES + 20);
    modelMem[5] = modelMem[5] & 16'h1234;
    modelSr[7]  = 1'b1;
    checkStatus("status_after_program");
    readArray(5, "program_word5");
    programWord(5, 16'h00FF);
    readArray(5, "program_and_semantics");

    applyStimulus(wa(0), 16'h00FF);
    checkLatency(5, 6);

    // Fill some words around block 1, then erase through word 70.
    programWord(63, 16'h5A5A);
    programWord(64, 16'h1111);
    programWord(100, 16'h2222);
    programWord(127, 16'h3333);
    programWord(128, 16'h4444);
    eraseBlock(70);
    checkStatus("status_after_erase");
    readArray(64, "erase_first_word");
    readArray(100, "erase_mid_word");
    readArray(127, "erase_last_word");
    readArray(63, "erase_below_block");
    readArray(128, "erase_above_block");
    readArray(5, "erase_other_word");

    applyStimulus(wa(70), 16'h0020);
    applyStimulus(wa(70), 16'h0030);
    modelSr = modelSr | 8'h30;
    checkStatus("erase_sequence_error");
    applyStimulus(wa(0), 16'h0050);
    modelSr = modelSr & 8'hC7;
    checkStatus("clear_status");
    readArray(128, "seq_error_no_change");

    vpen = 1'b0;
    programWord(9, 16'h0000);
    checkStatus("program_vpen_low");
    checkReady(1'b1, "vpen_low_no_busy");
    applyStimulus(wa(0), 16'h0050);
    modelSr = modelSr & 8'hC7;
    applyStimulus(wa(9), 16'h0020);
    applyStimulus(wa(9), 16'h00D0);
    modelSr = modelSr | 8'h28;
    checkStatus("erase_vpen_low");
    vpen = 1'b1;
    applyStimulus(wa(0), 16'h0050);
    modelSr = modelSr & 8'hC7;
    readArray(9, "vpen_low_no_change");

    // Commands while busy must not retarget or disturb the program.
    applyStimulus(wa(20), 16'h0040);
    busyQ.push_back(PROG_CYCLES);
    applyStimulus(wa(20), 16'h0F0F);
    applyStimulus(wa(21), 16'h00FF);
    waitReady(PROG_CYCLES + 20);
    modelMem[20] = modelMem[20] & 16'h0F0F;
    modelSr[7]   = 1'b1;
    checkStatus("busy_cmd_ignored");
    readArray(20, "busy_target_kept");
    readArray(21, "busy_other_untouched");

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 4);
      w  = $urandom_range(0, WORDS - 1);
      if (op <= 1) begin
        programWord(w, 16'($urandom));
        checkStatus("rand_program_status");
      end else if (op == 4 && i % 3 == 0) begin
        eraseBlock(w);
      end else begin
        readArray(w, "rand_read");
      end
    end

    // Abort an erase with rp_n low part way through.
    base = 256;
    programWord(base, 16'h0000);
    programWord(base + 1, 16'h0000);
    programWord(base + 62, 16'h0000);
    programWord(base + 63, 16'h0000);
    abortAt = $urandom_range(5, 40);
    applyStimulus(wa(base), 16'h0020);
    busyQ.push_back(abortAt + 1);
    applyStimulus(wa(base), 16'h00D0);
    repeat (abortAt) @(posedge clk);
    #1 rpN = 1'b0;
    @(posedge clk); #1;
    rpN = 1'b1;
    for (int i = 0; i < abortAt; i++) modelMem[base + i] = 16'hFFFF;
    modelSr = 8'h80;
    checkReady(1'b1, "abort_ready");
    checkOutput(wa(base + 63), modelMem[base + 63], "abort_read_array_mode");
    checkOutput(wa(base), modelMem[base], "abort_partial_erase");
    applyStimulus(wa(0), 16'h0070);
    checkStatus("abort_status");

    applyStimulus(wa(0), 16'h00FF);
    applyStimulus(wa(0), 16'h0090);
`ifdef FLASH_MODEL_ID_EN
    checkOutput(wa(0), 16'h0089, "id_word0");
    checkOutput(wa(1), 16'h0018, "id_word1");
    checkOutput(wa(2), 16'h0000, "id_word2");
`else
    checkOutput(wa(5), modelMem[5], "no_id_word5");
    checkOutput(wa(64), modelMem[64], "no_id_word64");
`endif

    endReq = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic checkLatency(input int a, input int b);
    flashAddr = wa(a);
    oeN       = 1'b0;
    @(posedge clk); #1;
    flashAddr = wa(b);
    expQ.push_back('{name: "latency_old", isReady: 1'b0, exp: modelMem[a]});
    strobe = 1'b1;
    @(posedge clk); #1;
    expQ.push_back('{name: "latency_new", isReady: 1'b0, exp: modelMem[b]});
    @(posedge clk); #1;
    strobe = 1'b0;
    oeN    = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
